// File: rtl/hex8_pkg.sv
// hex8_pkg: segment patterns, digit count and FSM states shared by the hex8 scan blocks
package hex8_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_CAPTURE, S_HOLD} state_t;
endpackage

// File: rtl/hex8_seg_decode.sv
// hex8_seg_decode: active-high 7-segment pattern to hex nibble with blank/invalid flags
module hex8_seg_decode
    import hex8_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_err
);
    // table lookup; any non-blank pattern that matches no hex glyph is an error
    always_comb begin
        nibble   = '0;
        is_blank = seg == 7'h00;
        is_err   = seg != 7'h00;
        for (int i = 0; i < 16; i++)
            if (seg == HEX_SEG[i]) begin
                nibble = 4'(i);
                is_err = 1'b0;
            end
    end
endmodule

// File: rtl/hex8_scan_decoder.sv
// hex8_scan_decoder: samples a multiplexed 8-digit 7-segment bus and rebuilds the 32-bit value
module hex8_scan_decoder
    import hex8_pkg::*;
#(
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 200_000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   sel_in,
    output logic [4*NUM_DIGITS-1:0] data_out,
    output logic                    data_valid,
    output logic                    changed,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    scan_lost
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [6:0]              seg_s1, seg_s2, seg_n, ref_seg;
    logic [NUM_DIGITS-1:0]   sel_s1, sel_s2, sel_n, ref_sel, seen, sh_blank, sh_err;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [SW-1:0]           cnt;
    logic [TW-1:0]           tcnt;
    logic [IW-1:0]           idx;
    logic [3:0]              nibble;
    logic                    is_blank, is_err, frame_pend, first_done;
    state_t                  state, state_nx;

    assign seg_n = seg_s2 ^ {7{SEG_ACT_LOW}};
    assign sel_n = sel_s2 ^ {NUM_DIGITS{SEL_ACT_LOW}};

    hex8_seg_decode u_dec (
        .seg      (ref_seg),
        .nibble   (nibble),
        .is_blank (is_blank),
        .is_err   (is_err)
    );

    // digit index of the latched one-hot select
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (ref_sel[i]) idx = IW'(i);
    end

    // next state: capture only after the bus held one-hot and unchanged for the settle window
    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT:    state_nx = $onehot(sel_n) ? S_SETTLE : S_WAIT;
            S_SETTLE:  state_nx = (sel_n != ref_sel || seg_n != ref_seg) ? S_WAIT :
                                  (cnt == SW'(SETTLE_CYC - 1)) ? S_CAPTURE : S_SETTLE;
            S_CAPTURE: state_nx = S_HOLD;
            default:   state_nx = (sel_n != ref_sel) ? S_WAIT : S_HOLD;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_WAIT;
        else     state <= state_nx;
    end

    // synchronisers, settle/timeout counters, shadow frame and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1     <= '0;
            seg_s2     <= '0;
            sel_s1     <= '0;
            sel_s2     <= '0;
            ref_seg    <= '0;
            ref_sel    <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            seen       <= '0;
            shadow     <= '0;
            sh_blank   <= '0;
            sh_err     <= '0;
            frame_pend <= 1'b0;
            first_done <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            changed    <= 1'b0;
            blank_mask <= '0;
            err_mask   <= '0;
            scan_lost  <= 1'b0;
        end else begin
            seg_s1     <= seg_in;
            seg_s2     <= seg_s1;
            sel_s1     <= sel_in;
            sel_s2     <= sel_s1;
            data_valid <= 1'b0;
            changed    <= 1'b0;
            frame_pend <= 1'b0;
            if (state == S_WAIT) begin
                ref_sel <= sel_n;
                ref_seg <= seg_n;
                cnt     <= '0;
            end else if (state == S_SETTLE) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_CAPTURE) begin
                shadow[{idx, 2'b00} +: 4] <= nibble;
                sh_blank[idx]             <= is_blank;
                sh_err[idx]               <= is_err;
                tcnt                      <= '0;
                scan_lost                 <= 1'b0;
                if ((seen | (NUM_DIGITS'(1) << idx)) == '1) begin
                    seen       <= '0;
                    frame_pend <= 1'b1;
                end else begin
                    seen[idx] <= 1'b1;
                end
            end else if (tcnt != TW'(TIMEOUT_CYC)) begin
                tcnt <= tcnt + 1'b1;
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    scan_lost <= 1'b1;
                    seen      <= '0;
                end
            end
            if (frame_pend) begin
                data_out   <= shadow;
                blank_mask <= sh_blank;
                err_mask   <= sh_err;
                data_valid <= 1'b1;
                changed    <= !first_done || shadow != data_out;
                first_done <= 1'b1;
            end
        end
    end
endmodule
